qs_prog_loader: RTL and testbench
=================================

QS_PROG_LOADER -- requirements
Module: qs_prog_loader

Interface
REQ-001 SHALL have parameter SYNC_BYTE, default 8'hA5: header byte that opens a load frame.
REQ-002 SHALL have ports clk (in, 1) and rst_n (in, 1): one clock; reset is synchronous and active-low.
REQ-003 SHALL have in_vld (in, 1), in_byte (in, 8) and in_rdy (out, 1): host byte stream; a byte transfers when in_vld && in_rdy.
REQ-004 SHALL have wr_vld (out, 1), wr_rdy (in, 1), wr_addr (out, 8, pc_t) and wr_data (out, 16, inst_t): instruction-RAM write; a write transfers when wr_vld && wr_rdy.
REQ-005 SHALL have busy (out, 1), done (out, 1), err (out, 1), err_code (out, 2) and entry_pc (out, 8).

Function
REQ-006 Frame format SHALL be: SYNC_BYTE, BASE, CNT, then CNT instruction words as two bytes each (high byte first), then CSUM; CNT=0 means 256 words.
REQ-007 States SHALL be IDLE, BASE, CNT, HI, LO, WR, CSUM.
REQ-008 IDLE SHALL accept and discard every byte; byte==SYNC_BYTE -> BASE, otherwise stay in IDLE with no other effect.
REQ-009 BASE SHALL latch the address pointer and go to CNT; CNT SHALL latch the remaining count and go to HI.
REQ-010 HI SHALL latch the high byte and go to LO; LO SHALL latch the low byte, form the 16-bit word and check its opcode (bits 15:12).
REQ-011 Legal opcodes SHALL be 0x0, 0x1, 0x2, 0x4, 0x6, 0x7, 0xC and 0xF; any other opcode SHALL cause a 1-cycle err pulse with err_code=2'd1 the cycle after the LO byte, no write, and a return to IDLE.
REQ-012 A legal word SHALL cause wr_vld=1 from the cycle after the LO byte, with wr_addr=pointer and wr_data=word, held stable until wr_rdy (state WR).
REQ-013 On the write handshake, pointer SHALL increment modulo 256 (0xFF wraps to 0x00) and count SHALL decrement; count reaching 0 -> CSUM, otherwise -> HI.
REQ-014 in_rdy SHALL be 1 in IDLE, BASE, CNT, HI, LO and CSUM, and 0 in WR and during reset.
REQ-015 The running checksum SHALL be the XOR of all instruction bytes (HI and LO) of the frame and SHALL be cleared on entry to BASE.
REQ-016 In CSUM: byte==checksum SHALL give a 1-cycle done pulse and entry_pc=BASE (held until the next done); a mismatch SHALL give a 1-cycle err pulse with err_code=2'd2; both cases -> IDLE.
REQ-017 Words already written SHALL NOT be rolled back on any error.
REQ-018 busy SHALL be 1 in every state except IDLE.
REQ-019 err_code SHALL hold its last value between err pulses; done and err SHALL never both be 1 in the same cycle.
REQ-020 The module SHALL NOT issue more than one write per word, and wr_vld SHALL be asserted only in WR.

Reset
REQ-021 When rst_n=0 at a clock edge: state=IDLE, wr_vld=0, in_rdy=0, busy=0, done=0, err=0, err_code=0, entry_pc=0, wr_addr=0, wr_data=0; pointer, count and checksum SHALL clear.
REQ-022 Reset mid-frame SHALL abandon the frame with no done or err pulse, and any pending write SHALL be dropped.
REQ-023 in_rdy SHALL be 1 the first cycle after rst_n returns to 1.

Verification
REQ-024 Stream A5,10,02,F8,00,F0,00,08 with wr_rdy=1 -> writes (0x10,0xF800) then (0x11,0xF000); done pulse; entry_pc=0x10; err stays 0.
REQ-025 Stream A5,FF,02,00,00,10,05,15 -> writes (0xFF,0x0000) then (0x00,0x1005) (address wrap); done pulse.
REQ-026 Stream A5,20,01,30,00 -> no write; err pulse with err_code=1; busy=0 next cycle; a following byte 0x30 is discarded in IDLE.
REQ-027 Stream A5,20,01,F8,00,00 (good checksum is F8) -> write (0x20,0xF800) performed; err pulse with err_code=2; entry_pc unchanged.
REQ-028 Same stream as REQ-024 with wr_rdy=0 for 5 cycles at the first write -> wr_vld, wr_addr=0x10 and wr_data=0xF800 stable and in_rdy=0 throughout; completes normally once wr_rdy=1.
REQ-029 rst_n=0 for 1 cycle after bytes A5,10,02,F8 -> no write, done or err; a complete new frame afterwards loads correctly.

Source files
------------

// File: rtl/qs_prog_loader_if.sv
// rtl/qs_prog_loader_if.sv - byte-stream and instruction-RAM write bus for qs_prog_loader
//
// Signals:
//   in_vld, in_byte, in_rdy      host byte stream (transfer when in_vld && in_rdy)
//   wr_vld, wr_rdy               instruction-RAM write handshake (transfer when wr_vld && wr_rdy)
//   wr_addr, wr_data             write address (pc) and instruction word
// Modports:
//   master  host / RAM side (drives the byte stream, accepts writes)
//   slave   loader side
interface qs_prog_loader_if;
    typedef logic [7:0]  pc_t;
    typedef logic [15:0] inst_t;

    logic        in_vld;
    logic [7:0]  in_byte;
    logic        in_rdy;
    logic        wr_vld;
    logic        wr_rdy;
    pc_t         wr_addr;
    inst_t       wr_data;

    modport master (
        output in_vld,
        output in_byte,
        output wr_rdy,
        input  in_rdy,
        input  wr_vld,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_vld,
        input  in_byte,
        input  wr_rdy,
        output in_rdy,
        output wr_vld,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/qs_prog_loader.sv
// rtl/qs_prog_loader.sv - framed program loader: byte stream to instruction-RAM writes
//
// Frame: SYNC_BYTE, BASE, CNT, CNT x {HI, LO}, CSUM  (CNT = 0 means 256 words).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   bus          qs_prog_loader_if.slave (byte stream in, RAM writes out)
//   busy         1 whenever a frame is in progress (state != IDLE)
//   done         1-cycle pulse on a good checksum
//   err          1-cycle pulse on an illegal opcode or checksum mismatch
//   err_code     1 = illegal opcode, 2 = checksum mismatch; holds between pulses
//   entry_pc     BASE of the last successfully loaded frame
module qs_prog_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    qs_prog_loader_if.slave       bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code,
    output logic [7:0]            entry_pc
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BASE = 3'd1,
        S_CNT  = 3'd2,
        S_HI   = 3'd3,
        S_LO   = 3'd4,
        S_WR   = 3'd5,
        S_CSUM = 3'd6
    } state_t;

    localparam logic [1:0] ERR_OPCODE = 2'd1;
    localparam logic [1:0] ERR_CSUM   = 2'd2;

    state_t      r_state;
    state_t      w_next;

    logic        r_live;        // low until the first clock edge out of reset; gates in_rdy
    logic [7:0]  r_ptr;         // address of the next word to write
    logic [7:0]  r_base;        // frame base, published on entry_pc at done
    logic [8:0]  r_cnt;         // words still to write; 9 bits so CNT=0 can hold 256
    logic [7:0]  r_hi;
    logic [7:0]  r_csum;
    logic [7:0]  r_wr_addr;
    logic [15:0] r_wr_data;
    logic        r_done;
    logic        r_err;
    logic [1:0]  r_err_code;
    logic [7:0]  r_entry_pc;

    logic        w_take;
    logic        w_wr_fire;
    logic [15:0] w_word;
    logic        w_legal;
    logic        w_in_rdy;
    logic        w_wr_vld;
    logic        w_busy;

    function automatic logic opcode_legal(input logic [3:0] op);
        case (op)
            4'h0, 4'h1, 4'h2, 4'h4, 4'h6, 4'h7, 4'hC, 4'hF: opcode_legal = 1'b1;
            default:                                       opcode_legal = 1'b0;
        endcase
    endfunction

    assign w_take    = bus.in_vld && w_in_rdy;
    assign w_wr_fire = w_wr_vld && bus.wr_rdy;
    assign w_word    = {r_hi, bus.in_byte};
    assign w_legal   = opcode_legal(w_word[15:12]);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_take && (bus.in_byte == SYNC_BYTE)) w_next = S_BASE;
            S_BASE: if (w_take) w_next = S_CNT;
            S_CNT:  if (w_take) w_next = S_HI;
            S_HI:   if (w_take) w_next = S_LO;
            S_LO:   if (w_take) w_next = w_legal ? S_WR : S_IDLE;
            S_WR:   if (w_wr_fire) w_next = (r_cnt == 9'd1) ? S_CSUM : S_HI;
            S_CSUM: if (w_take) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        w_in_rdy = 1'b0;
        w_wr_vld = 1'b0;
        w_busy   = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_in_rdy = r_live;
                w_busy   = 1'b0;
            end
            S_WR: begin
                w_wr_vld = 1'b1;
            end
            default: begin
                w_in_rdy = r_live;
            end
        endcase
    end

    // Frame datapath
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_live     <= 1'b0;
            r_ptr      <= 8'h00;
            r_base     <= 8'h00;
            r_cnt      <= 9'd0;
            r_hi       <= 8'h00;
            r_csum     <= 8'h00;
            r_wr_addr  <= 8'h00;
            r_wr_data  <= 16'h0000;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'd0;
            r_entry_pc <= 8'h00;
        end else begin
            r_live <= 1'b1;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_take && (bus.in_byte == SYNC_BYTE)) begin
                        r_csum <= 8'h00;
                    end
                end
                S_BASE: begin
                    if (w_take) begin
                        r_ptr  <= bus.in_byte;
                        r_base <= bus.in_byte;
                    end
                end
                S_CNT: begin
                    if (w_take) begin
                        r_cnt <= {(bus.in_byte == 8'h00), bus.in_byte};
                    end
                end
                S_HI: begin
                    if (w_take) begin
                        r_hi   <= bus.in_byte;
                        r_csum <= r_csum ^ bus.in_byte;
                    end
                end
                S_LO: begin
                    if (w_take) begin
                        if (w_legal) begin
                            r_wr_addr <= r_ptr;
                            r_wr_data <= w_word;
                            r_csum    <= r_csum ^ bus.in_byte;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_OPCODE;
                        end
                    end
                end
                S_WR: begin
                    if (w_wr_fire) begin
                        r_ptr <= r_ptr + 8'd1;
                        r_cnt <= r_cnt - 9'd1;
                    end
                end
                S_CSUM: begin
                    if (w_take) begin
                        if (bus.in_byte == r_csum) begin
                            r_done     <= 1'b1;
                            r_entry_pc <= r_base;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_code <= ERR_CSUM;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_rdy  = w_in_rdy;
    assign bus.wr_vld  = w_wr_vld;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign busy        = w_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign err_code    = r_err_code;
    assign entry_pc    = r_entry_pc;

endmodule

// File: tb/tb_qs_prog_loader.sv
// tb/tb_qs_prog_loader.sv - self-checking bench for qs_prog_loader
`define CHK(tag, obs, exp) begin n_checks++; assert ((obs) === (exp)) n_pass++; else $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end

module tb_qs_prog_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] err_code;
    logic [7:0] entry_pc;

    qs_prog_loader_if bus();

    qs_prog_loader #(.SYNC_BYTE(8'hA5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .err_code (err_code),
        .entry_pc (entry_pc)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [23:0] got_w[$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          both_cnt = 0;
    bit          rand_rdy = 1'b0;
    logic [7:0]  exp_entry = 8'h00;
    logic [1:0]  exp_code = 2'd0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_vld && bus.wr_rdy) got_w.push_back({bus.wr_addr, bus.wr_data});
            if (done) done_cnt++;
            if (err) err_cnt++;
            if (done && err) both_cnt++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus.wr_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    // Reference: walk the whole frame and derive writes and outcome
    // (0 = done, 1 = illegal opcode, 2 = checksum mismatch).
    task automatic model(input logic [7:0] f[$], output logic [23:0] ew[$], output int outcome);
        int n;
        logic [7:0] cs;
        logic [15:0] w;
        logic [3:0] op;
        ew.delete();
        cs = 8'h00;
        outcome = 0;
        n = (f[2] == 8'h00) ? 256 : int'(f[2]);
        for (int i = 0; i < n; i++) begin
            w = {f[3 + 2 * i], f[4 + 2 * i]};
            op = w[15:12];
            if (!(op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h6, 4'h7, 4'hC, 4'hF})) begin
                outcome = 1;
                return;
            end
            ew.push_back({8'(int'(f[1]) + i), w});
            cs = cs ^ f[3 + 2 * i] ^ f[4 + 2 * i];
        end
        outcome = (f[3 + 2 * n] == cs) ? 0 : 2;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        bus.in_vld = 1'b1;
        bus.in_byte = b;
        @(negedge clk);
        while (!bus.in_rdy && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_rdy) begin
            n_checks++;
            $error("FAIL in_rdy_timeout observed=0 expected=1");
        end
        @(posedge clk);
        #1;
        bus.in_vld = 1'b0;
    endtask

    task automatic clear_mon();
        got_w.delete();
        done_cnt = 0;
        err_cnt = 0;
        both_cnt = 0;
    endtask

    task automatic run_frame(input logic [7:0] f[$]);
        logic [23:0] ew[$];
        int outcome;
        model(f, ew, outcome);
        clear_mon();
        foreach (f[i]) send_byte(f[i]);
        `CHK("done_pulse", done, (outcome == 0))
        `CHK("err_pulse", err, (outcome != 0))
        `CHK("busy_at_end", busy, 1'b0)
        if (outcome == 0) exp_entry = f[1];
        if (outcome == 1) exp_code = 2'd1;
        if (outcome == 2) exp_code = 2'd2;
        repeat (3) @(posedge clk);
        #1;
        `CHK("n_writes", got_w.size(), ew.size())
        foreach (ew[i]) `CHK("write", got_w[i], ew[i])
        `CHK("done_count", done_cnt, (outcome == 0) ? 1 : 0)
        `CHK("err_count", err_cnt, (outcome != 0) ? 1 : 0)
        `CHK("done_err_overlap", both_cnt, 0)
        `CHK("err_code", err_code, exp_code)
        `CHK("entry_pc", entry_pc, exp_entry)
    endtask

    task automatic gen_frame(input int kind, input int n, output logic [7:0] f[$]);
        logic [3:0] legal [8] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h6, 4'h7, 4'hC, 4'hF};
        logic [3:0] bad   [8] = '{4'h3, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE};
        logic [7:0] cs;
        logic [7:0] hi;
        logic [7:0] lo;
        int badi;
        cs = 8'h00;
        f.delete();
        f.push_back(8'hA5);
        f.push_back(8'($urandom));
        f.push_back(8'(n));
        badi = (kind == 2) ? int'($urandom_range(0, n - 1)) : -1;
        for (int i = 0; i < n; i++) begin
            hi = {(i == badi) ? bad[$urandom_range(0, 7)] : legal[$urandom_range(0, 7)], 4'($urandom)};
            lo = 8'($urandom);
            f.push_back(hi);
            f.push_back(lo);
            cs = cs ^ hi ^ lo;
            if (i == badi) return;
        end
        f.push_back((kind == 1) ? (cs ^ 8'($urandom_range(1, 255))) : cs);
    endtask

    initial begin
        logic [7:0] q[$];
        bus.in_vld = 1'b0;
        bus.in_byte = 8'h00;
        bus.wr_rdy = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        `CHK("rst_in_rdy", bus.in_rdy, 1'b0)
        `CHK("rst_wr_vld", bus.wr_vld, 1'b0)
        `CHK("rst_busy", busy, 1'b0)
        `CHK("rst_done", done, 1'b0)
        `CHK("rst_err", err, 1'b0)
        `CHK("rst_err_code", err_code, 2'd0)
        `CHK("rst_entry_pc", entry_pc, 8'h00)
        `CHK("rst_wr_addr", bus.wr_addr, 8'h00)
        `CHK("rst_wr_data", bus.wr_data, 16'h0000)
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        `CHK("in_rdy_after_rst", bus.in_rdy, 1'b1)

        // Basic two-word load
        q = {8'hA5, 8'h10, 8'h02, 8'hF8, 8'h00, 8'hF0, 8'h00, 8'h08};
        run_frame(q);

        // Address wrap FF -> 00
        q = {8'hA5, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h10, 8'h05, 8'h15};
        run_frame(q);

        // Illegal opcode, then a stray byte discarded in IDLE
        q = {8'hA5, 8'h20, 8'h01, 8'h30, 8'h00};
        run_frame(q);
        clear_mon();
        send_byte(8'h30);
        `CHK("stray_busy", busy, 1'b0)
        repeat (2) @(posedge clk);
        #1;
        `CHK("stray_writes", got_w.size(), 0)
        `CHK("stray_err", err_cnt, 0)
        `CHK("stray_err_code_held", err_code, 2'd1)

        // Checksum mismatch after a completed write
        q = {8'hA5, 8'h20, 8'h01, 8'hF8, 8'h00, 8'h00};
        run_frame(q);

        // Write backpressure: request held stable, byte stream stalled
        clear_mon();
        bus.wr_rdy = 1'b0;
        q = {8'hA5, 8'h10, 8'h02, 8'hF8, 8'h00};
        foreach (q[i]) send_byte(q[i]);
        repeat (5) begin
            @(negedge clk);
            `CHK("bp_wr_vld", bus.wr_vld, 1'b1)
            `CHK("bp_wr_addr", bus.wr_addr, 8'h10)
            `CHK("bp_wr_data", bus.wr_data, 16'hF800)
            `CHK("bp_in_rdy", bus.in_rdy, 1'b0)
        end
        @(posedge clk);
        #1;
        bus.wr_rdy = 1'b1;
        send_byte(8'hF0);
        send_byte(8'h00);
        send_byte(8'h08);
        `CHK("bp_done", done, 1'b1)
        exp_entry = 8'h10;
        repeat (3) @(posedge clk);
        #1;
        `CHK("bp_n_writes", got_w.size(), 2)
        `CHK("bp_write0", got_w[0], 24'h10F800)
        `CHK("bp_write1", got_w[1], 24'h11F000)
        `CHK("bp_entry_pc", entry_pc, 8'h10)

        // Reset mid-frame
        clear_mon();
        q = {8'hA5, 8'h10, 8'h02, 8'hF8};
        foreach (q[i]) send_byte(q[i]);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        `CHK("midrst_in_rdy_low", bus.in_rdy, 1'b0)
        `CHK("midrst_busy", busy, 1'b0)
        exp_entry = 8'h00;
        exp_code = 2'd0;
        `CHK("midrst_entry_pc", entry_pc, exp_entry)
        `CHK("midrst_err_code", err_code, exp_code)
        @(posedge clk);
        #1;
        `CHK("midrst_in_rdy_high", bus.in_rdy, 1'b1)
        `CHK("midrst_writes", got_w.size(), 0)
        `CHK("midrst_done", done_cnt, 0)
        `CHK("midrst_err", err_cnt, 0)
        q = {8'hA5, 8'h10, 8'h02, 8'hF8, 8'h00, 8'hF0, 8'h00, 8'h08};
        run_frame(q);

        // Randomized frames with random write backpressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 14; k++) begin
            gen_frame(int'($urandom_range(0, 2)), int'($urandom_range(1, 6)), q);
            run_frame(q);
        end

        // CNT = 0 loads 256 words
        gen_frame(0, 256, q);
        run_frame(q);
        rand_rdy = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
